// File: rtl/scale_vector_datapath_if.sv
// -----------------------------------------------------------------------------
// scale_vector_datapath_if
//   Groups the control strobes, operands and results of the constant-by-vector
//   datapath into one bundle. The control stage (or a testbench) uses the
//   master modport; the datapath itself uses the slave modport.
//
//   Signals:
//     load        control -> datapath  capture constant and vector operands
//     shift       control -> datapath  process one element this cycle
//     flag        control -> datapath  operation complete, publish results
//     constant_in control -> datapath  nBits signed scalar multiplier
//     vector_in   control -> datapath  M*nBits operand vector, element i at
//                                      bits [i*nBits +: nBits]
//     vector_out  datapath -> control  M*nBits scaled vector, same packing
//     done        datapath -> control  one-cycle pulse: vector_out updated
//     overflow    datapath -> control  sticky saturation indicator
// -----------------------------------------------------------------------------
interface scale_vector_datapath_if #(
  parameter int nBits = 32,
  parameter int M     = 4
);

  logic                     load;
  logic                     shift;
  logic                     flag;
  logic [nBits-1:0]         constant_in;
  logic [M*nBits-1:0]       vector_in;
  logic [M*nBits-1:0]       vector_out;
  logic                     done;
  logic                     overflow;

  modport master (
    output load,
    output shift,
    output flag,
    output constant_in,
    output vector_in,
    input  vector_out,
    input  done,
    input  overflow
  );

  modport slave (
    input  load,
    input  shift,
    input  flag,
    input  constant_in,
    input  vector_in,
    output vector_out,
    output done,
    output overflow
  );

endinterface

// File: rtl/scale_vector_datapath.sv
// -----------------------------------------------------------------------------
// scale_vector_datapath
//   Multiplies every element of an M-element signed fixed-point vector
//   (Q(nBits-FRAC).FRAC) by a signed scalar, one element per shift cycle.
//   The product is taken at full 2*nBits width, arithmetically shifted right
//   by FRAC (truncation toward minus infinity) and saturated to nBits.
//
//   Operation, as sequenced by the external control stage:
//     load  : capture constant and vector, clear results, counter, overflow
//     shift : multiply operand element 0, push the product into result
//             element M-1 while both shift registers move down one element;
//             shifts beyond the M-th are ignored
//     flag  : publish the result register on vector_out, publish the internal
//             overflow, pulse done on the following cycle
//
//   Ports:
//     clk    input   clock, rising edge
//     reset  input   asynchronous, active-low; clears every register
//     bus    slave   scale_vector_datapath_if (load/shift/flag, constant_in,
//                    vector_in, vector_out, done, overflow)
// -----------------------------------------------------------------------------
module scale_vector_datapath #(
  parameter int nBits = 32,
  parameter int M     = 4,
  parameter int FRAC  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  scale_vector_datapath_if.slave bus
);

  localparam int PW = 2 * nBits;
  localparam int CW = $clog2(M + 1);
  localparam logic [CW-1:0] M_C = CW'(M);

  // Saturation bounds expressed at full product width.
  localparam logic signed [PW-1:0] SAT_MAX = {{(nBits+1){1'b0}}, {(nBits-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(nBits+1){1'b1}}, {(nBits-1){1'b0}}};

  // Rescale a full-width product and clamp it to nBits.
  // Returns {saturated, value}.
  function automatic logic [nBits:0] sat_rescale(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] s;
    s = p >>> FRAC;
    if (s > SAT_MAX) begin
      sat_rescale = {1'b1, SAT_MAX[nBits-1:0]};
    end else if (s < SAT_MIN) begin
      sat_rescale = {1'b1, SAT_MIN[nBits-1:0]};
    end else begin
      sat_rescale = {1'b0, s[nBits-1:0]};
    end
  endfunction

  // Architectural state.
  logic signed [nBits-1:0]     const_q, const_d;
  logic [M-1:0][nBits-1:0]     opnd_q,  opnd_d;
  logic [M-1:0][nBits-1:0]     res_q,   res_d;
  logic [M-1:0][nBits-1:0]     vout_q,  vout_d;
  logic [CW-1:0]               cnt_q,   cnt_d;
  logic                        ovf_int_q, ovf_int_d;
  logic                        ovf_q,   ovf_d;
  logic                        done_q,  done_d;

  // Stage 0: multiply the current head element and rescale/saturate.
  logic signed [PW-1:0]        opnd_ext_p0;
  logic signed [PW-1:0]        const_ext_p0;
  logic signed [PW-1:0]        prod_p0;
  logic [nBits:0]              sat_p0;
  logic                        accept_p0;

  always_comb begin
    opnd_ext_p0  = {{nBits{opnd_q[0][nBits-1]}}, opnd_q[0]};
    const_ext_p0 = {{nBits{const_q[nBits-1]}}, const_q};
    // Both operands are sign-extended, so the low PW bits of the product
    // are exact.
    prod_p0      = opnd_ext_p0 * const_ext_p0;
    sat_p0       = sat_rescale(prod_p0);
    accept_p0    = bus.shift && !bus.load && (cnt_q < M_C);
  end

  // Stage 1: next-state for the shift registers, counter and outputs.
  always_comb begin
    const_d   = const_q;
    opnd_d    = opnd_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    ovf_int_d = ovf_int_q;
    vout_d    = vout_q;
    ovf_d     = ovf_q;
    done_d    = bus.flag;

    // Publishing reads the pre-load result register, so flag and load in the
    // same cycle hand out the finished operation before it is cleared.
    if (bus.flag) begin
      vout_d = res_q;
      ovf_d  = ovf_int_q;
    end

    if (bus.load) begin
      const_d   = bus.constant_in;
      opnd_d    = bus.vector_in;
      res_d     = '0;
      cnt_d     = '0;
      ovf_int_d = 1'b0;
    end else if (accept_p0) begin
      for (int i = 0; i < M - 1; i++) begin
        res_d[i]  = res_q[i+1];
        opnd_d[i] = opnd_q[i+1];
      end
      res_d[M-1]  = sat_p0[nBits-1:0];
      opnd_d[M-1] = '0;
      cnt_d       = cnt_q + CW'(1);
      if (sat_p0[nBits]) begin
        ovf_int_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      const_q   <= '0;
      opnd_q    <= '0;
      res_q     <= '0;
      vout_q    <= '0;
      cnt_q     <= '0;
      ovf_int_q <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      const_q   <= const_d;
      opnd_q    <= opnd_d;
      res_q     <= res_d;
      vout_q    <= vout_d;
      cnt_q     <= cnt_d;
      ovf_int_q <= ovf_int_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign bus.vector_out = vout_q;
  assign bus.done       = done_q;
  assign bus.overflow   = ovf_q;

endmodule
